fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined core; the successor to the fixed two-stage forwarding logic. The block keeps its own shift-register scoreboard of in-flight destination registers instead of decoding the pipeline registers. It resolves forwarding for every source operand one cycle early, in ID, and registers the mux selects for EX. It also detects load-use hazards for a configurable load-data stage, honours memory back-pressure and branch flush, and counts inserted bubbles.

---
 rtl/fwd_scoreboard.sv | 112 +++++++++++
 tb/tb_fwd_scoreboard.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding and load-use hazard unit driven by a private
// shift-register scoreboard of in-flight destination registers.
//   clk, rst         : clock, synchronous active-high reset
//   id_*             : instruction currently in ID (sources, destination, load flag)
//   mem_stall        : pipeline frozen this cycle
//   flush            : squash the ID and EX instructions
//   stall_id         : combinational, hold ID and inject a bubble into EX
//   fwd_sel          : registered per-operand select for EX (0 = regfile, k = stage k)
//   fwd_from_mem     : registered, selected stage supplies load data
//   bubble_cnt       : saturating count of load-use bubbles
module fwd_scoreboard #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned N_SRC      = 3,
    parameter int unsigned N_FWD      = 2,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned FSEL_W    = $clog2(N_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [N_SRC*REG_AW-1:0]   id_src_addr,
    input  logic [N_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_dst_wr,
    input  logic                      id_is_load,
    input  logic                      mem_stall,
    input  logic                      flush,
    output logic                      stall_id,
    output logic [N_SRC*FSEL_W-1:0]   fwd_sel,
    output logic [N_SRC-1:0]          fwd_from_mem,
    output logic [CNT_W-1:0]          bubble_cnt
);

    // Scoreboard: entry 0 is the EX instruction, entry s is forwarding stage s.
    logic [N_FWD-1:0]  e_valid;
    logic [N_FWD-1:0]  e_load;
    logic [REG_AW-1:0] e_addr [N_FWD];

    logic [REG_AW-1:0] src      [N_SRC];
    logic [FSEL_W-1:0] win_sel  [N_SRC];
    logic [N_SRC-1:0]  win_load;
    logic [N_SRC-1:0]  hazard;
    logic              issue;

    // Unpack source operand addresses.
    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            src[i] = id_src_addr[i*REG_AW +: REG_AW];
        end
    end

    // Youngest-match search: scan oldest to youngest so the lowest s is kept.
    // Register 0 is never tracked or matched.
    always_comb begin
        win_sel  = '{default: '0};
        win_load = '0;
        hazard   = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            for (int s = int'(N_FWD) - 1; s >= 0; s--) begin
                if (id_src_used[i] && id_valid && (src[i] != '0) &&
                    e_valid[s] && (e_addr[s] == src[i])) begin
                    win_sel[i]  = FSEL_W'(s + 1);
                    win_load[i] = e_load[s];
                    hazard[i]   = e_load[s] && ((s + 1) < int'(LOAD_STAGE));
                end
            end
        end
    end

    assign stall_id = |hazard;
    assign issue    = id_valid & ~stall_id & ~mem_stall & ~flush;

    // Scoreboard advance, select registration and bubble counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid      <= '0;
            e_load       <= '0;
            for (int s = 0; s < int'(N_FWD); s++) begin
                e_addr[s] <= '0;
            end
            fwd_sel      <= '0;
            fwd_from_mem <= '0;
            bubble_cnt   <= '0;
        end else if (mem_stall) begin
            // Frozen; a flush still kills the EX instruction in place.
            if (flush) begin
                e_valid[0] <= 1'b0;
            end
        end else begin
            // A flushed EX instruction moves on into stage 1 as invalid.
            for (int s = int'(N_FWD) - 1; s > 0; s--) begin
                e_valid[s] <= (s == 1) ? (e_valid[0] & ~flush) : e_valid[s-1];
                e_addr[s]  <= e_addr[s-1];
                e_load[s]  <= e_load[s-1];
            end
            e_valid[0] <= issue & id_dst_wr & (id_dst_addr != '0);
            e_addr[0]  <= id_dst_addr;
            e_load[0]  <= id_is_load;

            for (int i = 0; i < int'(N_SRC); i++) begin
                fwd_sel[i*FSEL_W +: FSEL_W] <= issue ? win_sel[i] : '0;
                fwd_from_mem[i]             <= issue & win_load[i];
            end

            if (stall_id && !flush && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard: directed scenarios plus a randomized run
// checked against a queue-based pipeline history model.
module tb_fwd_scoreboard;

    localparam int REG_AW     = 5;
    localparam int N_SRC      = 3;
    localparam int N_FWD      = 2;
    localparam int LOAD_STAGE = 2;
    localparam int CNT_W      = 4;
    localparam int FSEL_W     = 2;

    logic                     clk;
    logic                     rst;
    logic                     id_valid;
    logic [N_SRC*REG_AW-1:0]  id_src_addr;
    logic [N_SRC-1:0]         id_src_used;
    logic [REG_AW-1:0]        id_dst_addr;
    logic                     id_dst_wr;
    logic                     id_is_load;
    logic                     mem_stall;
    logic                     flush;
    logic                     stall_id;
    logic [N_SRC*FSEL_W-1:0]  fwd_sel;
    logic [N_SRC-1:0]         fwd_from_mem;
    logic [CNT_W-1:0]         bubble_cnt;

    int total = 0;
    int bad   = 0;

    fwd_scoreboard #(
        .REG_AW(REG_AW), .N_SRC(N_SRC), .N_FWD(N_FWD),
        .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
        .id_is_load(id_is_load), .mem_stall(mem_stall), .flush(flush),
        .stall_id(stall_id), .fwd_sel(fwd_sel), .fwd_from_mem(fwd_from_mem),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FSEL_W-1:0] sel_of(input int i);
        return fwd_sel[i*FSEL_W +: FSEL_W];
    endfunction

    // Apply one ID-cycle of inputs at the falling edge; return 1 time unit later.
    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic [2:0] used, input logic [4:0] dst,
                         input logic wr, input logic ld,
                         input logic ms = 1'b0, input logic fl = 1'b0,
                         input logic r = 1'b0);
        @(negedge clk);
        id_valid    = v;
        id_src_addr = {5'd0, b, a};
        id_src_used = used;
        id_dst_addr = dst;
        id_dst_wr   = wr;
        id_is_load  = ld;
        mem_stall   = ms;
        flush       = fl;
        rst         = r;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        total++;
        if (fwd_sel !== 6'd0 || fwd_from_mem !== 3'd0 || bubble_cnt !== 4'd0 || stall_id !== 1'b0) begin
            bad++;
            $display("FAIL reset: sel=%h mem=%b cnt=%0d stall=%b, want all 0",
                     fwd_sel, fwd_from_mem, bubble_cnt, stall_id);
        end
    endtask

    task automatic test_alu_forward();
        drive(1'b1, 5'd1, 5'd2, 3'b011, 5'd3, 1'b1, 1'b0);   // add r3,r1,r2
        drive(1'b1, 5'd3, 5'd1, 3'b011, 5'd7, 1'b1, 1'b0);   // sub r7,r3,r1
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL alu_nostall: stall=%b want 0", stall_id); end
        drive(1'b1, 5'd3, 5'd0, 3'b001, 5'd9, 1'b1, 1'b0);   // reader of r3, distance 2
        total++;
        if (sel_of(0) !== 2'd1 || fwd_from_mem[0] !== 1'b0 || sel_of(1) !== 2'd0) begin
            bad++;
            $display("FAIL alu_dist1: selA=%0d memA=%b selB=%0d, want 1 0 0", sel_of(0), fwd_from_mem[0], sel_of(1));
        end
        idle();
        total++;
        if (sel_of(0) !== 2'd2 || fwd_from_mem[0] !== 1'b0) begin
            bad++;
            $display("FAIL alu_dist2: selA=%0d memA=%b, want 2 0", sel_of(0), fwd_from_mem[0]);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b1);   // lw r5
        drive(1'b1, 5'd5, 5'd5, 3'b011, 5'd6, 1'b1, 1'b0);   // add r6,r5,r5
        total++;
        if (stall_id !== 1'b1 || bubble_cnt !== 4'd0) begin
            bad++;
            $display("FAIL lu_stall: stall=%b cnt=%0d, want 1 0", stall_id, bubble_cnt);
        end
        drive(1'b1, 5'd5, 5'd5, 3'b011, 5'd6, 1'b1, 1'b0);   // held add
        total++;
        if (stall_id !== 1'b0 || bubble_cnt !== 4'd1 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL lu_bubble: stall=%b cnt=%0d sel=%h, want 0 1 0", stall_id, bubble_cnt, fwd_sel);
        end
        idle();
        total++;
        if (sel_of(0) !== 2'd2 || sel_of(1) !== 2'd2 || sel_of(2) !== 2'd0 || fwd_from_mem !== 3'b011) begin
            bad++;
            $display("FAIL lu_fwd: sel=%h mem=%b, want 0a 011", fwd_sel, fwd_from_mem);
        end
    endtask

    task automatic test_youngest();
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1, 1'b0);
        drive(1'b1, 5'd4, 5'd0, 3'b001, 5'd8, 1'b1, 1'b0);
        idle();
        total++;
        if (sel_of(0) !== 2'd1) begin bad++; $display("FAIL youngest: selA=%0d want 1", sel_of(0)); end
    endtask

    task automatic test_r0_unused();
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd0, 1'b1, 1'b1);   // lw r0
        drive(1'b1, 5'd0, 5'd0, 3'b011, 5'd2, 1'b1, 1'b0);   // reads r0
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL r0_stall: stall=%b want 0", stall_id); end
        idle();
        total++;
        if (fwd_sel !== 6'd0) begin bad++; $display("FAIL r0_sel: sel=%h want 0", fwd_sel); end
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd9, 1'b1, 1'b1);   // lw r9
        drive(1'b1, 5'd9, 5'd9, 3'b000, 5'd2, 1'b1, 1'b0);   // r9 named but unused
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL unused_stall: stall=%b want 0", stall_id); end
        idle();
        total++;
        if (fwd_sel !== 6'd0 || fwd_from_mem !== 3'd0) begin
            bad++; $display("FAIL unused_sel: sel=%h mem=%b want 0 0", fwd_sel, fwd_from_mem);
        end
    endtask

    task automatic test_mem_stall();
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd2, 1'b1, 1'b0);   // add r2
        drive(1'b1, 5'd2, 5'd0, 3'b001, 5'd5, 1'b1, 1'b1);   // lw r5,(r2)
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd5, 5'd5, 3'b011, 5'd6, 1'b1, 1'b0, 1'b1);
            total++;
            if (stall_id !== 1'b1 || bubble_cnt !== 4'd1 || sel_of(0) !== 2'd1) begin
                bad++;
                $display("FAIL ms_frozen%0d: stall=%b cnt=%0d selA=%0d, want 1 1 1", k, stall_id, bubble_cnt, sel_of(0));
            end
        end
        drive(1'b1, 5'd5, 5'd5, 3'b011, 5'd6, 1'b1, 1'b0);
        total++;
        if (stall_id !== 1'b1 || bubble_cnt !== 4'd1 || sel_of(0) !== 2'd1) begin
            bad++;
            $display("FAIL ms_release: stall=%b cnt=%0d selA=%0d, want 1 1 1", stall_id, bubble_cnt, sel_of(0));
        end
        drive(1'b1, 5'd5, 5'd5, 3'b011, 5'd6, 1'b1, 1'b0);
        total++;
        if (stall_id !== 1'b0 || bubble_cnt !== 4'd2 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL ms_bubble: stall=%b cnt=%0d sel=%h, want 0 2 0", stall_id, bubble_cnt, fwd_sel);
        end
        idle();
        total++;
        if (sel_of(0) !== 2'd2 || sel_of(1) !== 2'd2 || fwd_from_mem !== 3'b011) begin
            bad++;
            $display("FAIL ms_fwd: sel=%h mem=%b, want 0a 011", fwd_sel, fwd_from_mem);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd8, 1'b1, 1'b1);   // lw r8
        drive(1'b1, 5'd1, 5'd0, 3'b000, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd8, 5'd0, 3'b001, 5'd3, 1'b1, 1'b0);
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL flush_stall: stall=%b want 0", stall_id); end
        idle();
        total++;
        if (sel_of(0) !== 2'd0 || fwd_from_mem[0] !== 1'b0) begin
            bad++; $display("FAIL flush_sel: selA=%0d memA=%b want 0 0", sel_of(0), fwd_from_mem[0]);
        end
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd3, 1'b1, 1'b0);
        drive(1'b1, 5'd3, 5'd0, 3'b001, 5'd4, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        if (sel_of(0) !== 2'd1) begin bad++; $display("FAIL rst_pre: selA=%0d want 1", sel_of(0)); end
        drive(1'b1, 5'd3, 5'd0, 3'b001, 5'd4, 1'b1, 1'b0);
        total++;
        if (fwd_sel !== 6'd0 || fwd_from_mem !== 3'd0 || bubble_cnt !== 4'd0 || stall_id !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: sel=%h mem=%b cnt=%0d stall=%b, want all 0", fwd_sel, fwd_from_mem, bubble_cnt, stall_id);
        end
        idle();
        total++;
        if (sel_of(0) !== 2'd0) begin bad++; $display("FAIL rst_cleared: selA=%0d want 0", sel_of(0)); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b1);
            drive(1'b1, 5'd5, 5'd0, 3'b001, 5'd6, 1'b1, 1'b0);
            drive(1'b1, 5'd5, 5'd0, 3'b001, 5'd6, 1'b1, 1'b0);
            if (k == 9) begin
                total++;
                if (bubble_cnt !== 4'd10) begin bad++; $display("FAIL sat_mid: cnt=%0d want 10", bubble_cnt); end
            end
        end
        idle();
        total++;
        if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_end: cnt=%0d want 15", bubble_cnt); end
    endtask

    // Reference: a queue of what entered EX each advancing cycle, newest first.
    typedef struct {
        bit          wr;
        logic [4:0]  dst;
        bit          ld;
    } slot_t;

    task automatic test_random();
        slot_t       hist[$];
        slot_t       ns;
        int          exp_sel [N_SRC];
        bit          exp_mem [N_SRC];
        int          exp_cnt;
        int          d_win [N_SRC];
        bit          ld_win [N_SRC];
        bit          exp_stall;
        bit          iss;
        logic [4:0]  s_a [N_SRC];

        drive(1'b0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < N_FWD; s++) hist.push_back('{wr: 1'b0, dst: 5'd0, ld: 1'b0});
        for (int i = 0; i < N_SRC; i++) begin exp_sel[i] = 0; exp_mem[i] = 1'b0; end
        exp_cnt = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) < 2);
            mem_stall = ($urandom_range(0, 99) < 20);
            flush     = ($urandom_range(0, 99) < 8);
            id_valid  = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < N_SRC; i++) s_a[i] = 5'($urandom_range(0, 3));
            id_src_addr = {s_a[2], s_a[1], s_a[0]};
            id_src_used = 3'($urandom);
            id_dst_addr = 5'($urandom_range(0, 3));
            id_dst_wr   = ($urandom_range(0, 99) < 70);
            id_is_load  = ($urandom_range(0, 99) < 40);
            #1;

            exp_stall = 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                d_win[i]  = 0;
                ld_win[i] = 1'b0;
                if (id_valid && id_src_used[i] && s_a[i] != 5'd0) begin
                    for (int d = 1; d <= N_FWD; d++) begin
                        if (d_win[i] == 0 && hist[d-1].wr && hist[d-1].dst == s_a[i]) begin
                            d_win[i]  = d;
                            ld_win[i] = hist[d-1].ld;
                        end
                    end
                end
                if (ld_win[i] && d_win[i] < LOAD_STAGE) exp_stall = 1'b1;
            end

            total++;
            if (stall_id !== exp_stall) begin
                bad++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, stall_id, exp_stall);
            end
            for (int i = 0; i < N_SRC; i++) begin
                total++;
                if (sel_of(i) !== 2'(exp_sel[i]) || fwd_from_mem[i] !== exp_mem[i]) begin
                    bad++;
                    $display("FAIL rnd_sel c%0d op%0d: got sel=%0d mem=%b want sel=%0d mem=%b",
                             cyc, i, sel_of(i), fwd_from_mem[i], exp_sel[i], exp_mem[i]);
                end
            end
            total++;
            if (bubble_cnt !== 4'(exp_cnt)) begin
                bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, bubble_cnt, exp_cnt);
            end

            // Advance the model across the coming clock edge.
            if (rst) begin
                for (int s = 0; s < N_FWD; s++) hist[s].wr = 1'b0;
                for (int i = 0; i < N_SRC; i++) begin exp_sel[i] = 0; exp_mem[i] = 1'b0; end
                exp_cnt = 0;
            end else if (mem_stall) begin
                if (flush) hist[0].wr = 1'b0;
            end else begin
                iss = id_valid && !exp_stall && !flush;
                if (flush) hist[0].wr = 1'b0;
                ns.wr  = iss && id_dst_wr && id_dst_addr != 5'd0;
                ns.dst = id_dst_addr;
                ns.ld  = id_is_load;
                hist.push_front(ns);
                void'(hist.pop_back());
                for (int i = 0; i < N_SRC; i++) begin
                    exp_sel[i] = iss ? d_win[i] : 0;
                    exp_mem[i] = iss && ld_win[i];
                end
                if (exp_stall && !flush && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_src_addr = '0; id_src_used = '0;
        id_dst_addr = '0; id_dst_wr = 1'b0; id_is_load = 1'b0;
        mem_stall = 1'b0; flush = 1'b0;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_r0_unused();
        test_mem_stall();
        test_flush();
        test_rst_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
